// File: rtl/sext_packer_pkg.sv
// Shared types and the short-word rule for the sign-extension packer.
package sext_packer_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  // A word is short when its upper half is pure sign extension of bit 15.
  function automatic logic is_short(input logic [31:0] word);
    return (word[31:16] == {16{word[15]}});
  endfunction

endpackage

// File: rtl/sext_packer_sext_check.sv
// Combinational short/long classifier for a 32-bit word.
module sext_check
  import sext_packer_pkg::*;
(
  input  logic [31:0] i_data,
  output logic        o_short
);

  assign o_short = is_short(i_data);

endmodule

// File: rtl/sext_packer.sv
// Packs 32-bit words into 16-bit beats: one beat when the word is a
// sign-extended halfword, two beats (low then high) otherwise.
module sext_packer
  import sext_packer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_short,
  output logic             out_last,
  output logic [CNT_W-1:0] short_cnt,
  output logic [CNT_W-1:0] long_cnt
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_word;
  logic        r_short;
  logic        w_short;
  logic        w_in_xfer;
  logic        w_out_xfer;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  sext_check u_check (
    .i_data  (in_data),
    .o_short (w_short)
  );

  always_comb begin
    out_valid = 1'b0;
    out_data  = 16'h0000;
    out_short = 1'b0;
    out_last  = 1'b0;
    case (r_state)
      SEND_LO: begin
        out_valid = 1'b1;
        out_data  = r_word[15:0];
        out_short = r_short;
        out_last  = r_short;
      end
      SEND_HI: begin
        out_valid = 1'b1;
        out_data  = r_word[31:16];
        out_last  = 1'b1;
      end
      default: ;
    endcase
    // Accepting alongside the final beat keeps short words flowing at one per cycle.
    in_ready   = rst_n && ((r_state == EMPTY) || (out_ready && out_last));
    w_in_xfer  = in_valid && in_ready;
    w_out_xfer = out_valid && out_ready;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_in_xfer) begin
      w_state_nxt = SEND_LO;
    end else if (w_out_xfer) begin
      w_state_nxt = out_last ? EMPTY : SEND_HI;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= EMPTY;
      r_word    <= 32'h0;
      r_short   <= 1'b0;
      short_cnt <= '0;
      long_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_in_xfer) begin
        r_word  <= in_data;
        r_short <= w_short;
        if (w_short) begin
          short_cnt <= sat_inc(short_cnt);
        end else begin
          long_cnt  <= sat_inc(long_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_sext_packer.sv
// Randomised and directed bench for sext_packer against a beat-queue model.
module tb_sext_packer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_short;
  logic        out_last;
  logic [15:0] short_cnt;
  logic [15:0] long_cnt;

  logic        n_in_ready;
  logic        n_out_valid;
  logic [15:0] n_out_data;
  logic        n_out_short;
  logic        n_out_last;
  logic [1:0]  n_short_cnt;
  logic [1:0]  n_long_cnt;

  sext_packer #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_short(out_short), .out_last(out_last),
    .short_cnt(short_cnt), .long_cnt(long_cnt)
  );

  sext_packer #(.CNT_W(2)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_data(in_data), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_data(n_out_data), .out_short(n_out_short), .out_last(n_out_last),
    .short_cnt(n_short_cnt), .long_cnt(n_long_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        s;
    logic        l;
  } beat_t;

  beat_t q[$];
  int    m_short, m_long, m_short2, m_long2;
  int    checks, failures;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_short(input logic [31:0] w);
    int sv;
    sv = $signed(w);
    return (sv >= -32768) && (sv <= 32767);
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v + 1 > maxv) ? maxv : v + 1;
  endfunction

  task automatic step(input bit rv, input bit iv, input logic [31:0] d, input bit ordy);
    bit    exp_ov, exp_ir, sh;
    beat_t b;
    rst_n = rv; in_valid = iv; in_data = d; out_ready = ordy;
    @(negedge clk);
    exp_ov = (q.size() != 0);
    b = exp_ov ? q[0] : '0;
    exp_ir = rv && (!exp_ov || (ordy && b.l));
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
    check("out_data", {16'b0, out_data}, {16'b0, b.d});
    check("out_short", {31'b0, out_short}, {31'b0, b.s});
    check("out_last", {31'b0, out_last}, {31'b0, b.l});
    check("in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
    check("short_cnt", {16'b0, short_cnt}, m_short);
    check("long_cnt", {16'b0, long_cnt}, m_long);
    check("short_cnt_w2", {30'b0, n_short_cnt}, m_short2);
    check("long_cnt_w2", {30'b0, n_long_cnt}, m_long2);
    check("w2_out_data", {16'b0, n_out_data}, {16'b0, b.d});
    if (!rv) begin
      q.delete();
      m_short = 0; m_long = 0; m_short2 = 0; m_long2 = 0;
    end else begin
      if (exp_ov && ordy) void'(q.pop_front());
      if (iv && exp_ir) begin
        sh = model_short(d);
        if (sh) begin
          q.push_back('{d: d[15:0], s: 1'b1, l: 1'b1});
          m_short = sat(m_short, 65535);
          m_short2 = sat(m_short2, 3);
        end else begin
          q.push_back('{d: d[15:0], s: 1'b0, l: 1'b0});
          q.push_back('{d: d[31:16], s: 1'b0, l: 1'b1});
          m_long = sat(m_long, 65535);
          m_long2 = sat(m_long2, 3);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bnd [6];
  logic [31:0] tmp;
  logic [31:0] d;

  initial begin
    bnd[0] = 32'h00008000; bnd[1] = 32'hFFFF8000; bnd[2] = 32'h00007FFF;
    bnd[3] = 32'hFFFF7FFF; bnd[4] = 32'h00000000; bnd[5] = 32'hFFFFFFFF;
    checks = 0; failures = 0;
    m_short = 0; m_long = 0; m_short2 = 0; m_long2 = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    step(0, 1, 32'h1, 1);
    step(0, 0, 32'h0, 0);

    // Single short word 0xFFFFFFF3
    step(1, 1, 32'hFFFFFFF3, 1);
    check("req033_data", {16'b0, out_data}, 32'h0000FFF3);
    step(1, 0, 32'h0, 1);
    check("req033_cnt", {16'b0, short_cnt}, 32'd1);

    // Long word 0x12345678
    step(1, 1, 32'h12345678, 1);
    check("req034_ready_lo", {31'b0, in_ready}, 32'd0);
    step(1, 0, 32'h0, 1);
    step(1, 0, 32'h0, 1);
    step(1, 0, 32'h0, 1);

    // Back-to-back short stream
    step(1, 1, 32'h00000001, 1);
    step(1, 1, 32'h00000002, 1);
    step(1, 1, 32'h00000003, 1);
    step(1, 0, 32'h0, 1);
    step(1, 0, 32'h0, 1);

    // 0x00008000 with three stall cycles per beat
    step(1, 1, 32'h00008000, 0);
    repeat (3) step(1, 0, 32'h0, 0);
    step(1, 0, 32'h0, 1);
    repeat (3) step(1, 0, 32'h0, 0);
    step(1, 0, 32'h0, 1);
    step(1, 0, 32'h0, 1);

    // Reset during SEND_HI of 0xABCD0001
    step(1, 1, 32'hABCD0001, 1);
    step(1, 0, 32'h0, 1);
    step(0, 0, 32'h0, 0);
    step(1, 0, 32'h0, 1);
    check("req037_valid", {31'b0, out_valid}, 32'd0);
    step(1, 0, 32'h0, 1);

    // Narrow counter saturation: five short words
    for (int i = 0; i < 5; i++) step(1, 1, 32'h00000010 + i, 1);
    step(1, 0, 32'h0, 1);
    check("req038_sat", {30'b0, n_short_cnt}, 32'd3);

    // Randomised traffic with boundary words and occasional reset
    for (int i = 0; i < 600; i++) begin
      tmp = $urandom;
      case ($urandom_range(0, 3))
        0: d = tmp;
        1: d = {{16{tmp[15]}}, tmp[15:0]};
        2: d = bnd[$urandom_range(0, 5)];
        default: d = {16'h0000, tmp[15:0]};
      endcase
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), d,
           ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sext_packer.md
SEXT_PACKER -- requirements
Module: sext_packer

Interface
REQ-001 Parameter: CNT_W, default 16, width of each statistics counter.
REQ-002 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous and active-low.
REQ-004 Port: in_valid  input  1  upstream presents a 32-bit word.
REQ-005 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-006 Port: in_data  input  32  word to be packed.
REQ-007 Port: out_valid  output  1  beat present on out_data.
REQ-008 Port: out_ready  input  1  downstream accepts the beat.
REQ-009 Port: out_data  output  16  beat payload.
REQ-010 Port: out_short  output  1  1 = the single beat sign-extends to the full word.
REQ-011 Port: out_last  output  1  1 = final beat of the current word.
REQ-012 Port: short_cnt  output  CNT_W  count of words accepted as short.
REQ-013 Port: long_cnt  output  CNT_W  count of words accepted as long.

Function
REQ-014 Input transfer SHALL occur on a cycle with in_valid && in_ready; output transfer SHALL occur on a cycle with out_valid && out_ready.
REQ-015 A word SHALL be short iff in_data[31:16] == {16{in_data[15]}}; otherwise it SHALL be long.
REQ-016 FSM states SHALL be EMPTY, SEND_LO, SEND_HI; reset state EMPTY.
REQ-017 An accepted word SHALL be registered; the first beat SHALL be valid the cycle after acceptance (latency 1).
REQ-018 A short word SHALL produce exactly one beat: out_data=word[15:0], out_short=1, out_last=1 (state SEND_LO).
REQ-019 A long word SHALL produce two beats in order: word[15:0] with out_short=0, out_last=0 (SEND_LO), then word[31:16] with out_short=0, out_last=1 (SEND_HI).
REQ-020 SEND_LO SHALL go to SEND_HI on output transfer of a non-last beat; any state SHALL go to EMPTY on output transfer of a last beat with no input transfer that cycle.
REQ-021 in_ready SHALL be 1 in EMPTY, and 1 on a cycle where the last beat is transferred; 0 otherwise.
REQ-022 Input transfer concurrent with a last-beat transfer SHALL load the new word and enter SEND_LO next cycle with no bubble (one short word per cycle sustained).
REQ-023 While out_valid && !out_ready, out_data, out_short, out_last SHALL hold stable.
REQ-024 out_valid SHALL be 0 in EMPTY; out_data, out_short, out_last SHALL be 0 in EMPTY.
REQ-025 short_cnt/long_cnt SHALL increment by 1 on the cycle of input transfer per REQ-015 classification, and SHALL saturate at 2^CNT_W-1.
REQ-026 0x00008000 SHALL classify long; 0xFFFF8000 and 0x00007FFF SHALL classify short.

Reset
REQ-027 With rst_n low at a rising edge: state=EMPTY, word register=0, short_cnt=0, long_cnt=0, out_valid=0, out_data=0, out_short=0, out_last=0.
REQ-028 in_ready SHALL be 0 while rst_n is low; no transfer SHALL be counted during reset.
REQ-029 Reset asserted mid-word (SEND_LO or SEND_HI) SHALL discard the remaining beats; no beat of that word SHALL appear after reset.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and the short-word classification function.
REQ-031 One sub-module, sext_check (32-bit in, 1-bit short flag out, combinational), SHALL implement REQ-015.
REQ-032 Counters SHALL reside in sext_packer, not in sext_check.

Verification
REQ-033 Reset then in_data=0xFFFFFFF3, out_ready=1 -> next cycle one beat 0xFFF3, short=1, last=1; short_cnt=1.
REQ-034 in_data=0x12345678, out_ready=1 -> beats 0x5678 (short=0, last=0) then 0x1234 (last=1); long_cnt=1; in_ready=0 during the first beat.
REQ-035 Stream 0x00000001, 0x00000002, 0x00000003 with out_ready=1 -> beats 0x0001, 0x0002, 0x0003 on consecutive cycles; short_cnt=3.
REQ-036 Long word 0x00008000 with out_ready low for 3 cycles on each beat -> 0x8000 then 0x0000 held stable until accepted; no extra beats.
REQ-037 rst_n low during SEND_HI of 0xABCD0001 -> out_valid=0 next cycle, counters=0, beat 0xABCD never emitted.
REQ-038 CNT_W=2, five short words -> short_cnt saturates at 3.
